if_id_fetch_buffer: RTL and testbench

- IF/ID boundary block, directly downstream of the PC stage.
- Takes the current PC and the combinational ROM read data, and presents a registered instruction, PC and valid flag to the ID stage.
- ROM is shared with the MEM stage, so the ROM data bus is not a valid instruction when the PC stage flags a ROM load/store. A one-entry replay buffer keeps an already-fetched instruction across stalls and conflicts.
- Bubble and conflict counters are kept for performance debug.

---
 rtl/if_id_fetch_buffer_pkg.sv | 17 +
 rtl/if_id_fetch_buffer_if.sv | 26 ++
 rtl/if_id_fetch_buffer_replay_buf.sv | 66 ++++++
 rtl/if_id_fetch_buffer.sv | 78 +++++++
 tb/tb_if_id_fetch_buffer.sv | 131 +++++++++++++
 5 files changed

// File: rtl/if_id_fetch_buffer_pkg.sv
// Shared types and constants for the IF/ID fetch buffer and its replay buffer.
package if_id_fetch_buffer_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0000;

  // Bit positions inside the CTRL stall vector
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/if_id_fetch_buffer_if.sv
// Bundle of CTRL/PC-stage inputs and ID-stage/debug outputs of the fetch buffer.
interface if_id_fetch_buffer_if #(parameter int CNT_W = 32);
  import if_id_fetch_buffer_pkg::*;

  logic              flush;
  logic [4:0]        stall;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              load_store_rom_i;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_valid;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output flush, stall, if_pc, if_inst, load_store_rom_i,
    input  id_pc, id_inst, id_valid, bubble_cnt, conflict_cnt
  );

  modport slave (
    input  flush, stall, if_pc, if_inst, load_store_rom_i,
    output id_pc, id_inst, id_valid, bubble_cnt, conflict_cnt
  );

endinterface

// File: rtl/if_id_fetch_buffer_replay_buf.sv
// One-entry replay buffer: keeps a fetched instruction alive across IF stalls
// and ROM conflicts, tagged with its PC.
module replay_buf
  import if_id_fetch_buffer_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              capture,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              load_store_rom_i,
  output logic              buf_hit,
  output logic [INST_W-1:0] buf_inst
);

  buf_state_t        state, state_nxt;
  logic [ADDR_W-1:0] buf_pc;
  logic              load;

  assign buf_hit = (state == BUF_FULL) && (buf_pc == if_pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BUF_EMPTY;
      buf_pc   <= '0;
      buf_inst <= NOP_INST;
    end else begin
      state <= state_nxt;
      if (load) begin
        buf_pc   <= if_pc;
        buf_inst <= if_inst;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    if (flush) begin
      state_nxt = BUF_EMPTY;
    end else if (!capture) begin
      // IF advances: the entry is consumed whenever ID takes a real instruction
      if (buf_hit || !load_store_rom_i) state_nxt = BUF_EMPTY;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (!load_store_rom_i) begin
            state_nxt = BUF_FULL;
            load      = 1'b1;
          end
        end
        BUF_FULL: begin
          if (!buf_hit) begin
            if (!load_store_rom_i) load = 1'b1;
            else                   state_nxt = BUF_EMPTY;
          end
        end
        default: state_nxt = BUF_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/if_id_fetch_buffer.sv
// IF/ID pipeline register with ROM-conflict replay and bubble/conflict counters.
module if_id_fetch_buffer
  import if_id_fetch_buffer_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF,
  parameter int                CNT_W    = 32
) (
  input logic                 clk,
  input logic                 rst,
  if_id_fetch_buffer_if.slave bus
);

  logic              if_stop, id_stop, advance, id_bubble, capture;
  logic              buf_hit, src_ok;
  logic [INST_W-1:0] buf_inst, src_inst;
  logic [CNT_W-1:0]  bubble_cnt, conflict_cnt;
  logic              unused_stall;

  assign unused_stall = ^{bus.stall[4:3], bus.stall[0]};

  assign if_stop   = bus.stall[STALL_IF];
  assign id_stop   = bus.stall[STALL_ID];
  // stall[1]=0 with stall[2]=1 falls into the full-hold case
  assign advance   = !if_stop && !id_stop;
  assign id_bubble = if_stop && !id_stop;
  assign capture   = if_stop || id_stop;

  assign src_ok   = buf_hit || !bus.load_store_rom_i;
  assign src_inst = buf_hit ? buf_inst : bus.if_inst;

  replay_buf #(.NOP_INST(NOP_INST)) u_replay_buf (
    .clk              (clk),
    .rst              (rst),
    .flush            (bus.flush),
    .capture          (capture),
    .if_pc            (bus.if_pc),
    .if_inst          (bus.if_inst),
    .load_store_rom_i (bus.load_store_rom_i),
    .buf_hit          (buf_hit),
    .buf_inst         (buf_inst)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.id_pc    <= '0;
      bus.id_inst  <= NOP_INST;
      bus.id_valid <= 1'b0;
      bubble_cnt   <= '0;
    end else if (bus.flush) begin
      bus.id_pc    <= '0;
      bus.id_inst  <= NOP_INST;
      bus.id_valid <= 1'b0;
    end else if (advance) begin
      bus.id_pc <= bus.if_pc;
      if (src_ok) begin
        bus.id_inst  <= src_inst;
        bus.id_valid <= 1'b1;
      end else begin
        bus.id_inst  <= NOP_INST;
        bus.id_valid <= 1'b0;
        bubble_cnt   <= bubble_cnt + 1'b1;
      end
    end else if (id_bubble) begin
      bus.id_inst  <= NOP_INST;
      bus.id_valid <= 1'b0;
      bubble_cnt   <= bubble_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     conflict_cnt <= '0;
    else if (bus.load_store_rom_i && !bus.flush) conflict_cnt <= conflict_cnt + 1'b1;
  end

  assign bus.bubble_cnt   = bubble_cnt;
  assign bus.conflict_cnt = conflict_cnt;

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Directed, table-driven bench for the IF/ID fetch buffer.
module tb_if_id_fetch_buffer;
  import if_id_fetch_buffer_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  if_id_fetch_buffer_if #(.CNT_W(32)) bus ();

  if_id_fetch_buffer #(.NOP_INST(NOP), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [4:0]  stall;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ls;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;
    logic [31:0] e_bub;
    logic [31:0] e_conf;
  } vec_t;

  vec_t vecs [25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                           input logic e_valid, input logic [31:0] e_bub, input logic [31:0] e_conf);
    check({tag, ".id_pc"},        bus.id_pc,        e_pc);
    check({tag, ".id_inst"},      bus.id_inst,      e_inst);
    check({tag, ".id_valid"},     {31'd0, bus.id_valid}, {31'd0, e_valid});
    check({tag, ".bubble_cnt"},   bus.bubble_cnt,   e_bub);
    check({tag, ".conflict_cnt"}, bus.conflict_cnt, e_conf);
  endtask

  task automatic drive(input logic fl, input logic [4:0] st, input logic [31:0] pc,
                       input logic [31:0] inst, input logic ls);
    bus.flush            = fl;
    bus.stall            = st;
    bus.if_pc            = pc;
    bus.if_inst          = inst;
    bus.load_store_rom_i = ls;
  endtask

  initial begin
    //          flush stall     pc            inst          ls   e_pc          e_inst        v  bub conf
    vecs[0]  = '{0, 5'b00000, 32'hBFC0_0000, 32'h3401_0001, 0, 32'hBFC0_0000, 32'h3401_0001, 1, 0, 0};
    // two-cycle ROM conflict, then real fetch
    vecs[1]  = '{0, 5'b00000, 32'h8000_0010, 32'hDEAD_BEEF, 1, 32'h8000_0010, NOP,           0, 1, 1};
    vecs[2]  = '{0, 5'b00000, 32'h8000_0010, 32'hDEAD_BEEF, 1, 32'h8000_0010, NOP,           0, 2, 2};
    vecs[3]  = '{0, 5'b00000, 32'h8000_0010, 32'h8C22_0004, 0, 32'h8000_0010, 32'h8C22_0004, 1, 2, 2};
    // full stall with conflict inside, release during conflict replays buffer
    vecs[4]  = '{0, 5'b00111, 32'h8000_0020, 32'h2442_0001, 0, 32'h8000_0010, 32'h8C22_0004, 1, 2, 2};
    vecs[5]  = '{0, 5'b00111, 32'h8000_0020, 32'hDEAD_BEEF, 1, 32'h8000_0010, 32'h8C22_0004, 1, 2, 3};
    vecs[6]  = '{0, 5'b00111, 32'h8000_0020, 32'h2442_0001, 0, 32'h8000_0010, 32'h8C22_0004, 1, 2, 3};
    vecs[7]  = '{0, 5'b00000, 32'h8000_0020, 32'hDEAD_BEEF, 1, 32'h8000_0020, 32'h2442_0001, 1, 2, 4};
    // IF-only stall: bubble, then single issue, then next instruction
    vecs[8]  = '{0, 5'b00011, 32'h8000_0024, 32'h27BD_FFF8, 0, 32'h8000_0020, NOP,           0, 3, 4};
    vecs[9]  = '{0, 5'b00000, 32'h8000_0024, 32'h27BD_FFF8, 0, 32'h8000_0024, 32'h27BD_FFF8, 1, 3, 4};
    vecs[10] = '{0, 5'b00000, 32'h8000_0028, 32'hAFBF_0004, 0, 32'h8000_0028, 32'hAFBF_0004, 1, 3, 4};
    // illegal stall[1]=0/stall[2]=1 behaves as a full hold with capture
    vecs[11] = '{0, 5'b00101, 32'h8000_002C, 32'h1111_1111, 0, 32'h8000_0028, 32'hAFBF_0004, 1, 3, 4};
    vecs[12] = '{0, 5'b00000, 32'h8000_002C, 32'hDEAD_BEEF, 1, 32'h8000_002C, 32'h1111_1111, 1, 3, 5};
    // tag mismatch reloads the buffer
    vecs[13] = '{0, 5'b00011, 32'h8000_0030, 32'h2222_2222, 0, 32'h8000_002C, NOP,           0, 4, 5};
    vecs[14] = '{0, 5'b00111, 32'h8000_0034, 32'h3333_3333, 0, 32'h8000_002C, NOP,           0, 4, 5};
    vecs[15] = '{0, 5'b00000, 32'h8000_0034, 32'hDEAD_BEEF, 1, 32'h8000_0034, 32'h3333_3333, 1, 4, 6};
    // tag mismatch during conflict invalidates the buffer
    vecs[16] = '{0, 5'b00111, 32'h8000_0038, 32'h4444_4444, 0, 32'h8000_0034, 32'h3333_3333, 1, 4, 6};
    vecs[17] = '{0, 5'b00111, 32'h8000_003C, 32'hDEAD_BEEF, 1, 32'h8000_0034, 32'h3333_3333, 1, 4, 7};
    vecs[18] = '{0, 5'b00000, 32'h8000_0038, 32'hDEAD_BEEF, 1, 32'h8000_0038, NOP,           0, 5, 8};
    // flush with full buffer: no stale replay afterwards, counters frozen
    vecs[19] = '{0, 5'b00111, 32'h8000_0180, 32'h5555_5555, 0, 32'h8000_0038, NOP,           0, 5, 8};
    vecs[20] = '{1, 5'b00111, 32'h8000_0180, 32'hDEAD_BEEF, 1, 32'h0000_0000, NOP,           0, 5, 8};
    vecs[21] = '{0, 5'b00000, 32'h8000_0180, 32'h6666_6666, 0, 32'h8000_0180, 32'h6666_6666, 1, 5, 8};
    vecs[22] = '{1, 5'b00011, 32'h8000_0184, 32'hDEAD_BEEF, 1, 32'h0000_0000, NOP,           0, 5, 8};
    // fill buffer ahead of asynchronous reset
    vecs[23] = '{0, 5'b00000, 32'h8000_0184, 32'h1234_5678, 0, 32'h8000_0184, 32'h1234_5678, 1, 5, 8};
    vecs[24] = '{0, 5'b00111, 32'h8000_0200, 32'h7777_7777, 0, 32'h8000_0184, 32'h1234_5678, 1, 5, 8};

    drive(0, 5'b00000, 32'h0, 32'h0, 0);
    #2;
    check_all("reset", 32'h0, NOP, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(vecs[i].flush, vecs[i].stall, vecs[i].pc, vecs[i].inst, vecs[i].ls);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_valid,
                vecs[i].e_bub, vecs[i].e_conf);
    end

    // asynchronous reset between clock edges clears everything at once
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 32'h0, NOP, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // same PC as the pre-reset buffer entry under conflict must bubble
    drive(0, 5'b00000, 32'h8000_0200, 32'hDEAD_BEEF, 1);
    @(posedge clk);
    #1;
    check_all("post_rst", 32'h8000_0200, NOP, 1'b0, 32'd1, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
